// File: rtl/mem_pkg.sv
// Shared definitions for the posted-write store buffer.
//   sb_state_t : request sequencer states
//   sb_entry_t : one buffered store {word address, data} in the default 32/32 geometry
//   WORD_OFS   : byte-offset bits dropped from word addresses
package mem_pkg;

    localparam int WORD_OFS = 2;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_DRAIN,
        SB_READ,
        SB_RDONE
    } sb_state_t;

    typedef struct packed {
        logic [SB_AW-1:WORD_OFS] addr;
        logic [SB_DW-1:0]        data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue with associative youngest-match lookup.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (pointers/count only)
//   push, push_addr, push_data   enqueue at tail (caller guarantees !full)
//   pop               drop head entry (caller guarantees !empty)
//   lookup_addr       word address searched among valid entries
//   count, full, empty   occupancy
//   head_addr/data    oldest entry
//   next_addr/data    entry behind the head (valid when count >= 2)
//   hit, hit_data     youngest valid entry whose address equals lookup_addr
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [AW-1:WORD_OFS] push_addr,
    input  logic [DW-1:0]        push_data,
    input  logic                 pop,
    input  logic [AW-1:WORD_OFS] lookup_addr,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 empty,
    output logic [AW-1:WORD_OFS] head_addr,
    output logic [DW-1:0]        head_data,
    output logic [AW-1:WORD_OFS] next_addr,
    output logic [DW-1:0]        next_data,
    output logic                 hit,
    output logic [DW-1:0]        hit_data
);

    logic [AW-1:WORD_OFS] addr_q [DEPTH];
    logic [DW-1:0]        data_q [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW-1:0]        next_idx;
    logic [PW-1:0]        idx;

    // Entry storage carries no reset; validity comes from head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign next_idx  = head + 1'b1;
    assign head_addr = addr_q[head];
    assign head_data = data_q[head];
    assign next_addr = addr_q[next_idx];
    assign next_data = data_q[next_idx];

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the CPU memory stage and a slow
// single-port data memory. Stores are queued and drained in order; loads
// hit the queue (youngest match) or go to memory with the CPU stalled.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   MemWrite, MemRead, ALUResult, WriteDataM   CPU memory-stage request
//   ReadData, Stall, SbEmpty      CPU-side results / status
//   mem_req, mem_we, mem_addr, mem_wdata       registered memory request
//   mem_ack, mem_rdata            memory handshake / read data
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] ALUResult,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadData,
    output logic          Stall,
    output logic          SbEmpty,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t            state;
    sb_state_t            state_nxt;
    logic [DW-1:0]        rdata_q;
    logic [AW-1:WORD_OFS] word_addr;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic [AW-1:WORD_OFS] head_addr;
    logic [DW-1:0]        head_data;
    logic [AW-1:WORD_OFS] next_addr;
    logic [DW-1:0]        next_data;
    logic                 hit;
    logic [DW-1:0]        hit_data;
    logic                 push;
    logic                 pop;
    logic                 rd_req;
    logic                 load_miss;
    logic                 more;
    logic                 start_read;
    logic                 start_write;
    logic                 end_req;
    logic [AW-1:WORD_OFS] wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 unused_addr_lsb;

    assign word_addr       = ALUResult[AW-1:WORD_OFS];
    assign unused_addr_lsb = ^ALUResult[WORD_OFS-1:0];

    // A full buffer refuses the store even if a drain ack frees a slot now.
    assign push      = MemWrite && !full;
    assign rd_req    = MemRead && !MemWrite;
    assign load_miss = rd_req && !hit && (state != SB_RDONE);
    assign pop       = (state == SB_DRAIN) && mem_ack;
    // Something is left to drain after this pop, counting a same-edge store.
    assign more      = (count > CW'(1)) || push;

    sb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (word_addr),
        .push_data   (WriteDataM),
        .pop         (pop),
        .lookup_addr (word_addr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .next_addr   (next_addr),
        .next_data   (next_data),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE: begin
                if (load_miss)   state_nxt = SB_READ;
                else if (!empty) state_nxt = SB_DRAIN;
            end
            SB_DRAIN: begin
                if (mem_ack) begin
                    if (load_miss) state_nxt = SB_READ;
                    else if (more) state_nxt = SB_DRAIN;
                    else           state_nxt = SB_IDLE;
                end
            end
            SB_READ: begin
                if (mem_ack) state_nxt = SB_RDONE;
            end
            default: state_nxt = SB_IDLE;
        endcase
    end

    always_comb begin
        Stall       = (MemWrite && full) || load_miss;
        ReadData    = '0;
        if (state == SB_RDONE)  ReadData = rdata_q;
        else if (rd_req && hit) ReadData = hit_data;
        start_read  = 1'b0;
        start_write = 1'b0;
        end_req     = 1'b0;
        wr_addr     = head_addr;
        wr_data     = head_data;
        case (state)
            SB_IDLE: begin
                if (load_miss)   start_read  = 1'b1;
                else if (!empty) start_write = 1'b1;
            end
            SB_DRAIN: begin
                if (mem_ack) begin
                    if (load_miss) begin
                        start_read = 1'b1;
                    end else if (more) begin
                        start_write = 1'b1;
                        // With one entry left, the next head is the store landing now.
                        if (count > CW'(1)) begin
                            wr_addr = next_addr;
                            wr_data = next_data;
                        end else begin
                            wr_addr = word_addr;
                            wr_data = WriteDataM;
                        end
                    end else begin
                        end_req = 1'b1;
                    end
                end
            end
            SB_READ: begin
                if (mem_ack) end_req = 1'b1;
            end
            default: ;
        endcase
    end

    // Request registers hold steady from assertion through the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start_read) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {word_addr, {WORD_OFS{1'b0}}};
        end else if (start_write) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {wr_addr, {WORD_OFS{1'b0}}};
            mem_wdata <= wr_data;
        end else if (end_req) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           rdata_q <= '0;
        else if (state == SB_READ && mem_ack) rdata_q <= mem_rdata;
    end

    assign SbEmpty = (count == '0) && (state != SB_DRAIN);

endmodule
